ram_arbiter_2ch: RTL and testbench

Two-client access controller for the 64x16 dual-port (one write port, one read port) synchronous RAM. After reset it clears every RAM location to INIT_VALUE. It then shares the RAM's write and read ports between client A and client B using a req/gnt handshake, with round-robin resolution when both clients want the same port. It sits directly in front of the RAM instance and owns all of its control, address and write-data inputs.

---
 rtl/ram_arbiter_2ch.sv | 146 ++++++++++++++
 tb/tb_ram_arbiter_2ch.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_2ch.sv
// ram_arbiter_2ch: clears a dual-port RAM after reset, then shares its write
// and read ports between clients A and B with round-robin on same-port conflict.
module ram_arbiter_2ch #(
    parameter int unsigned       ADDR_W     = 6,
    parameter int unsigned       DATA_W     = 16,
    parameter bit                INIT_EN    = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              init_done,
    output logic              wr_enable,
    output logic              rd_enable,
    output logic [ADDR_W-1:0] wr_adress,
    output logic [ADDR_W-1:0] rd_adress,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'((2 ** ADDR_W) - 1);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     init_cnt_q, init_cnt_d;
    logic                rr_last_q, rr_last_d;
    logic                pend_a_q, pend_a_d;
    logic                pend_b_q, pend_b_d;
    logic                init_done_q;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic run;
    logic sweep;
    logic conflict;
    logic wr_en;
    logic rd_en;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        rr_last_d  = rr_last_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        wdata_d    = wdata_q;
        wr_en      = 1'b0;
        rd_en      = 1'b0;

        run   = (state_q == ST_RUN) && !reset;
        sweep = (state_q == ST_INIT) && !reset;

        // Same-port contention: the client other than rr_last wins.
        conflict = a_req && b_req && (a_we == b_we);
        a_gnt    = run && a_req && !(conflict && !rr_last_q);
        b_gnt    = run && b_req && !(conflict && rr_last_q);

        if (run && conflict) begin
            rr_last_d = !rr_last_q;
        end

        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end

        if (sweep) begin
            wr_en     = 1'b1;
            wr_addr_d = init_cnt_q[ADDR_W-1:0];
            wdata_d   = INIT_VALUE;
        end else if (a_gnt && a_we) begin
            wr_en     = 1'b1;
            wr_addr_d = a_addr;
            wdata_d   = a_wdata;
        end else if (b_gnt && b_we) begin
            wr_en     = 1'b1;
            wr_addr_d = b_addr;
            wdata_d   = b_wdata;
        end

        if (a_gnt && !a_we) begin
            rd_en     = 1'b1;
            rd_addr_d = a_addr;
        end else if (b_gnt && !b_we) begin
            rd_en     = 1'b1;
            rd_addr_d = b_addr;
        end

        pend_a_d = a_gnt && !a_we;
        pend_b_d = b_gnt && !b_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT_EN ? ST_INIT : ST_RUN;
            init_cnt_q  <= '0;
            rr_last_q   <= 1'b1;
            pend_a_q    <= 1'b0;
            pend_b_q    <= 1'b0;
            init_done_q <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rr_last_q   <= rr_last_d;
            pend_a_q    <= pend_a_d;
            pend_b_q    <= pend_b_d;
            init_done_q <= (state_d == ST_RUN);
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Reset is synchronous, so registered outputs are masked while it is high.
    assign a_rvalid  = pend_a_q && !reset;
    assign b_rvalid  = pend_b_q && !reset;
    assign init_done = init_done_q && !reset;
    assign rdata     = data_out;
    assign wr_enable = wr_en;
    assign rd_enable = rd_en;
    assign wr_adress = wr_addr_d;
    assign rd_adress = rd_addr_d;
    assign data_in   = wdata_d;

endmodule

// File: tb/tb_ram_arbiter_2ch.sv
// tb_ram_arbiter_2ch: drives ram_arbiter_2ch in front of a behavioural RAM
// and checks grants, sweep and read data against a reference model.
module tb_ram_arbiter_2ch;

    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, b_req, a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, init_done;
    logic [DW-1:0] rdata;
    logic          wr_enable, rd_enable;
    logic [AW-1:0] wr_adress, rd_adress;
    logic [DW-1:0] data_in, data_out;

    logic          preload;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    int checks = 0;
    int errors = 0;
    // 1 when B won the most recent conflict (A wins the next one)
    bit m_last_b = 1'b1;

    ram_arbiter_2ch dut (
        .clk       (clk),
        .reset     (reset),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .a_gnt     (a_gnt),
        .b_gnt     (b_gnt),
        .a_rvalid  (a_rvalid),
        .b_rvalid  (b_rvalid),
        .rdata     (rdata),
        .init_done (init_done),
        .wr_enable (wr_enable),
        .rd_enable (rd_enable),
        .wr_adress (wr_adress),
        .rd_adress (rd_adress),
        .data_in   (data_in),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    // RAM with registered read; a same-cycle write leaves the old value on data_out
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 16'hFFFF;
        end else begin
            if (rd_enable) data_out <= mem[rd_adress];
            if (wr_enable) mem[wr_adress] <= data_in;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; preload = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b1; b_we = 1'b1; b_addr = '0; b_wdata = '0;
        tick();
        preload = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({a_gnt, b_gnt, wr_enable, rd_enable, a_rvalid, b_rvalid, init_done} !== 7'b0) begin
                errors++;
                $display("FAIL rst_outputs c=%0d got %b exp 0000000", c,
                         {a_gnt, b_gnt, wr_enable, rd_enable, a_rvalid, b_rvalid, init_done});
            end
            tick();
        end
        // write request presented during the sweep must survive until RUN
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'd7; a_wdata = 16'hA5A5;
        b_req = 1'b0;
    endtask

    task automatic test_sweep();
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        reset = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            if (init_done === 1'b1) begin
                seen = 1'b1;
            end else begin
                checks++;
                if ({wr_enable, wr_adress, data_in} !== {1'b1, AW'(n), 16'h0000}) begin
                    errors++;
                    $display("FAIL sweep_write n=%0d got we=%b a=%0d d=%h", n,
                             wr_enable, wr_adress, data_in);
                end
                checks++;
                if ({a_gnt, b_gnt, rd_enable, a_rvalid, b_rvalid} !== 5'b0) begin
                    errors++;
                    $display("FAIL sweep_quiet n=%0d got %b exp 00000", n,
                             {a_gnt, b_gnt, rd_enable, a_rvalid, b_rvalid});
                end
                n++;
                tick();
            end
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL sweep_len got %0d exp 64", n);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
        m_last_b = 1'b1;
    endtask

    task automatic test_held_request();
        checks++;
        if ({a_gnt, b_gnt, wr_enable, wr_adress, data_in} !== {3'b101, 6'd7, 16'hA5A5}) begin
            errors++;
            $display("FAIL held_req got g=%b%b we=%b a=%0d d=%h", a_gnt, b_gnt,
                     wr_enable, wr_adress, data_in);
        end
        ref_mem[7] = 16'hA5A5;
        tick();
        a_req = 1'b0;
    endtask

    task automatic test_clear_reads();
        int addrs[3] = '{0, 31, 63};
        for (int k = 0; k < 3; k++) begin
            b_req = 1'b1; b_we = 1'b0; b_addr = AW'(addrs[k]);
            @(negedge clk);
            checks++;
            if ({b_gnt, rd_enable, rd_adress} !== {2'b11, AW'(addrs[k])}) begin
                errors++;
                $display("FAIL clr_gnt a=%0d got g=%b re=%b ra=%0d", addrs[k],
                         b_gnt, rd_enable, rd_adress);
            end
            tick();
            b_req = 1'b0;
            @(negedge clk);
            checks++;
            if ({b_rvalid, a_rvalid, rdata} !== {2'b10, ref_mem[addrs[k]]}) begin
                errors++;
                $display("FAIL clr_read a=%0d got v=%b%b d=%h exp 10 %h", addrs[k],
                         b_rvalid, a_rvalid, rdata, ref_mem[addrs[k]]);
            end
            tick();
        end
    endtask

    task automatic test_simple();
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'd5; a_wdata = 16'hBEEF;
        @(negedge clk);
        checks++;
        if ({a_gnt, b_gnt, wr_enable, wr_adress, data_in} !== {3'b101, 6'd5, 16'hBEEF}) begin
            errors++;
            $display("FAIL simple_wr got g=%b%b we=%b a=%0d d=%h", a_gnt, b_gnt,
                     wr_enable, wr_adress, data_in);
        end
        ref_mem[5] = 16'hBEEF;
        tick();
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'd5;
        @(negedge clk);
        checks++;
        if ({b_gnt, rd_enable, rd_adress, a_rvalid} !== {2'b11, 6'd5, 1'b0}) begin
            errors++;
            $display("FAIL simple_rd_gnt got g=%b re=%b ra=%0d av=%b", b_gnt,
                     rd_enable, rd_adress, a_rvalid);
        end
        tick();
        b_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({b_rvalid, a_rvalid, rdata} !== {2'b10, ref_mem[5]}) begin
            errors++;
            $display("FAIL simple_rd_data got v=%b%b d=%h exp 10 %h", b_rvalid,
                     a_rvalid, rdata, ref_mem[5]);
        end
        tick();
    endtask

    task automatic test_concurrent();
        logic [DW-1:0] old;
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'd9; a_wdata = 16'h1234;
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'd9;
        @(negedge clk);
        checks++;
        if ({a_gnt, b_gnt, wr_enable, rd_enable} !== 4'b1111) begin
            errors++;
            $display("FAIL conc_gnt got %b exp 1111", {a_gnt, b_gnt, wr_enable, rd_enable});
        end
        old = ref_mem[9];
        ref_mem[9] = 16'h1234;
        tick();
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({b_rvalid, rdata} !== {1'b1, old}) begin
            errors++;
            $display("FAIL conc_old got v=%b d=%h exp 1 %h", b_rvalid, rdata, old);
        end
        tick();
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'd9;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1) begin
            errors++;
            $display("FAIL conc_rd_gnt got %b exp 1", a_gnt);
        end
        tick();
        a_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_rvalid, b_rvalid, rdata} !== {2'b10, ref_mem[9]}) begin
            errors++;
            $display("FAIL conc_new got v=%b%b d=%h exp 10 %h", a_rvalid, b_rvalid,
                     rdata, ref_mem[9]);
        end
        tick();
    endtask

    task automatic test_write_conflict();
        logic [DW-1:0] da[4];
        logic [DW-1:0] db[4];
        int ia, ib;
        bit exp_a;
        for (int i = 0; i < 4; i++) begin
            da[i] = DW'($urandom);
            db[i] = da[i] ^ 16'h5A5A ^ DW'(i + 1);
        end
        ia = 0;
        ib = 0;
        for (int c = 0; c < 4; c++) begin
            a_req = 1'b1; a_we = 1'b1; a_addr = 6'd1; a_wdata = da[ia];
            b_req = 1'b1; b_we = 1'b1; b_addr = 6'd2; b_wdata = db[ib];
            @(negedge clk);
            exp_a = m_last_b;
            checks++;
            if ({a_gnt, b_gnt} !== {exp_a, ~exp_a}) begin
                errors++;
                $display("FAIL wc_order c=%0d got %b%b exp %b%b", c, a_gnt, b_gnt,
                         exp_a, ~exp_a);
            end
            checks++;
            if ({wr_enable, wr_adress, data_in} !==
                {1'b1, exp_a ? 6'd1 : 6'd2, exp_a ? da[ia] : db[ib]}) begin
                errors++;
                $display("FAIL wc_port c=%0d got we=%b a=%0d d=%h", c, wr_enable,
                         wr_adress, data_in);
            end
            if (exp_a) begin
                ref_mem[1] = da[ia];
                ia++;
            end else begin
                ref_mem[2] = db[ib];
                ib++;
            end
            m_last_b = ~exp_a;
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
        tick();
        checks++;
        if ({mem[1], mem[2]} !== {ref_mem[1], ref_mem[2]}) begin
            errors++;
            $display("FAIL wc_mem got %h %h exp %h %h", mem[1], mem[2],
                     ref_mem[1], ref_mem[2]);
        end
    endtask

    task automatic test_read_conflict();
        bit prev_a, prev_b, exp_a;
        logic [DW-1:0] prev_d;
        prev_a = 1'b0; prev_b = 1'b0; prev_d = '0;
        a_addr = AW'($urandom);
        b_addr = AW'($urandom);
        for (int c = 0; c < 8; c++) begin
            a_req = 1'b1; a_we = 1'b0;
            b_req = 1'b1; b_we = 1'b0;
            @(negedge clk);
            exp_a = m_last_b;
            checks++;
            if ({a_gnt, b_gnt} !== {exp_a, ~exp_a}) begin
                errors++;
                $display("FAIL rc_gnt c=%0d got %b%b exp %b%b", c, a_gnt, b_gnt,
                         exp_a, ~exp_a);
            end
            checks++;
            if ({a_rvalid, b_rvalid} !== {prev_a, prev_b}) begin
                errors++;
                $display("FAIL rc_rvalid c=%0d got %b%b exp %b%b", c, a_rvalid,
                         b_rvalid, prev_a, prev_b);
            end
            if (prev_a || prev_b) begin
                checks++;
                if (rdata !== prev_d) begin
                    errors++;
                    $display("FAIL rc_rdata c=%0d got %h exp %h", c, rdata, prev_d);
                end
            end
            prev_a = exp_a;
            prev_b = ~exp_a;
            prev_d = ref_mem[exp_a ? a_addr : b_addr];
            m_last_b = ~exp_a;
            tick();
            if (exp_a) a_addr = AW'($urandom);
            else b_addr = AW'($urandom);
        end
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_rvalid, b_rvalid, rdata} !== {prev_a, prev_b, prev_d}) begin
            errors++;
            $display("FAIL rc_last got v=%b%b d=%h exp %b%b %h", a_rvalid, b_rvalid,
                     rdata, prev_a, prev_b, prev_d);
        end
        tick();
    endtask

    task automatic test_random();
        bit ra, rb, wa, wb, pa, pb, conf, ea, eb, ewe, ere;
        logic [AW-1:0] aa, ab;
        logic [DW-1:0] da, db, pd;
        ra = 1'b0; rb = 1'b0; wa = 1'b0; wb = 1'b0; pa = 1'b0; pb = 1'b0;
        aa = '0; ab = '0; da = '0; db = '0; pd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!ra && $urandom_range(0, 9) < 6) begin
                ra = 1'b1;
                wa = 1'($urandom_range(0, 1));
                aa = AW'($urandom_range(0, 7));
                da = DW'($urandom);
            end
            if (!rb && $urandom_range(0, 9) < 6) begin
                rb = 1'b1;
                wb = 1'($urandom_range(0, 1));
                ab = AW'($urandom_range(0, 7));
                db = DW'($urandom);
            end
            a_req = ra; a_we = wa; a_addr = aa; a_wdata = da;
            b_req = rb; b_we = wb; b_addr = ab; b_wdata = db;
            @(negedge clk);
            conf = ra && rb && (wa == wb);
            ea = ra && (!conf || m_last_b);
            eb = rb && (!conf || !m_last_b);
            ewe = (ea && wa) || (eb && wb);
            ere = (ea && !wa) || (eb && !wb);
            checks++;
            if ({a_gnt, b_gnt, wr_enable, rd_enable} !== {ea, eb, ewe, ere}) begin
                errors++;
                $display("FAIL rnd_gnt c=%0d got %b exp %b", c,
                         {a_gnt, b_gnt, wr_enable, rd_enable}, {ea, eb, ewe, ere});
            end
            checks++;
            if ({a_rvalid, b_rvalid} !== {pa, pb}) begin
                errors++;
                $display("FAIL rnd_rvalid c=%0d got %b%b exp %b%b", c, a_rvalid,
                         b_rvalid, pa, pb);
            end
            if (pa || pb) begin
                checks++;
                if (rdata !== pd) begin
                    errors++;
                    $display("FAIL rnd_rdata c=%0d got %h exp %h", c, rdata, pd);
                end
            end
            pa = ea && !wa;
            pb = eb && !wb;
            if (pa || pb) begin
                checks++;
                if (rd_adress !== (pa ? aa : ab)) begin
                    errors++;
                    $display("FAIL rnd_raddr c=%0d got %0d exp %0d", c, rd_adress,
                             pa ? aa : ab);
                end
                pd = ref_mem[pa ? aa : ab];
            end
            if (ewe) begin
                checks++;
                if ({wr_adress, data_in} !== ((ea && wa) ? {aa, da} : {ab, db})) begin
                    errors++;
                    $display("FAIL rnd_wport c=%0d got a=%0d d=%h", c, wr_adress, data_in);
                end
                if (ea && wa) ref_mem[aa] = da;
                else ref_mem[ab] = db;
            end
            if (conf) m_last_b = eb;
            if (ea) ra = 1'b0;
            if (eb) rb = 1'b0;
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_rvalid, b_rvalid} !== {pa, pb} || ((pa || pb) && rdata !== pd)) begin
            errors++;
            $display("FAIL rnd_tail got v=%b%b d=%h exp %b%b %h", a_rvalid, b_rvalid,
                     rdata, pa, pb, pd);
        end
        tick();
        checks++;
        if (mem[0:7] !== ref_mem[0:7]) begin
            errors++;
            $display("FAIL rnd_mem contents differ in addresses 0..7");
        end
    endtask

    task automatic test_reset_mid();
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'd3; b_req = 1'b0;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1) begin
            errors++;
            $display("FAIL mid_gnt got %b exp 1", a_gnt);
        end
        tick();
        a_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_rvalid, b_rvalid, init_done, wr_enable, rd_enable} !== 5'b0) begin
            errors++;
            $display("FAIL mid_rst got %b exp 00000",
                     {a_rvalid, b_rvalid, init_done, wr_enable, rd_enable});
        end
        tick();
        test_sweep();
        tick();
        // pointer is back at its reset value, so A takes the first conflict
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'd10; a_wdata = 16'h1111;
        b_req = 1'b1; b_we = 1'b1; b_addr = 6'd11; b_wdata = 16'h2222;
        @(negedge clk);
        checks++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL mid_rr got %b%b exp 10", a_gnt, b_gnt);
        end
        tick();
        a_req = 1'b0; b_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_held_request();
        test_clear_reads();
        test_simple();
        test_concurrent();
        test_write_conflict();
        test_read_conflict();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
